lsu_ctrl: RTL

Load/store initiator for the MEM stage. It accepts one load or store per request from the pipeline and drives the data-memory port: address, data, funct3, MemRead and MemWrite. Aligned accesses are issued as a single memory operation. Misaligned halfword and word accesses are split into sequential byte operations. Load results are reassembled, sign- or zero-extended and returned with the destination register; the pipeline stalls while the block is busy.

---
 rtl/lsu_ctrl_pkg.sv | 41 ++++
 rtl/lsu_ctrl_if.sv | 51 +++++
 rtl/lsu_ctrl_load_extend.sv | 27 ++
 rtl/lsu_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl shared definitions: funct3 codes, state encodings,
// request bundle and access-size helper.
package lsu_ctrl_pkg;

  localparam logic [31:0] MEM_BASE_DEF = 32'h400;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_SPLIT  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

  // Bytes touched by a funct3; 0 marks a reserved width.
  function automatic logic [2:0] f3_size(
    input logic [2:0] f3
  );
    unique case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and data-memory port of lsu_ctrl.
// slave = LSU side, master = pipeline + memory side.
interface lsu_ctrl_if;
  import lsu_ctrl_pkg::*;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        resp_fault_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [2:0]  mem_funct3_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i,
    input  req_funct3_i, req_addr_i,
    input  req_wdata_i, req_rd_i,
    input  mem_rdata_i,
    output req_ready_o, stall_o,
    output resp_valid_o, resp_data_o,
    output resp_rd_o, resp_fault_o,
    output mem_addr_o, mem_data_o,
    output mem_funct3_o,
    output mem_read_o, mem_write_o
  );

  modport master (
    output req_valid_i, req_we_i,
    output req_funct3_i, req_addr_i,
    output req_wdata_i, req_rd_i,
    output mem_rdata_i,
    input  req_ready_o, stall_o,
    input  resp_valid_o, resp_data_o,
    input  resp_rd_o, resp_fault_o,
    input  mem_addr_o, mem_data_o,
    input  mem_funct3_o,
    input  mem_read_o, mem_write_o
  );

endinterface

// File: rtl/lsu_ctrl_load_extend.sv
// Load result extension from the little-endian assembly buffer.
// Ports: funct3_i, buf_i (assembled bytes) -> data_o.
module lsu_ctrl_load_extend
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] buf_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = buf_i;
    unique case (1'b1)
      (funct3_i == F3_LB):
        data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      (funct3_i == F3_LH):
        data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      (funct3_i == F3_LBU):
        data_o = {24'b0, buf_i[7:0]};
      (funct3_i == F3_LHU):
        data_o = {16'b0, buf_i[15:0]};
      default:
        data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store initiator; splits misaligned accesses.
// Ports: sys_clk, sys_reset (async high), bus (lsu_ctrl_if.slave).
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter logic [31:0] MEM_BASE         = MEM_BASE_DEF,
  parameter int unsigned MEM_BYTES        = 64,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  lsu_ctrl_if.slave   bus
);

  logic [1:0]  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        fault_q, fault_d;

  lsu_req_t    in_req;
  logic [2:0]  in_size;
  logic        in_legal, in_oob;
  logic        in_mis, in_fault;
  logic [32:0] in_last, mem_last;
  logic [1:0]  last_cnt;
  logic [31:0] ext;

  assign in_req = {bus.req_we_i, bus.req_funct3_i,
                   bus.req_addr_i, bus.req_wdata_i,
                   bus.req_rd_i};
  assign in_size = f3_size(in_req.f3);

  assign in_legal = in_req.we ?
    (in_req.f3 inside {F3_SB, F3_SH, F3_SW}) :
    (in_req.f3 inside {F3_LB, F3_LH, F3_LW,
                       F3_LBU, F3_LHU});

  // 33-bit sums so an access near 2^32 cannot wrap into range.
  assign in_last  = {1'b0, in_req.addr}
                  + {30'b0, in_size} - 33'd1;
  assign mem_last = {1'b0, MEM_BASE}
                  + 33'(MEM_BYTES) - 33'd1;
  assign in_oob   = (in_req.addr < MEM_BASE)
                  || (in_last > mem_last);

  assign in_mis = ((in_size == 3'd2) && in_req.addr[0])
               || ((in_size == 3'd4)
                   && (in_req.addr[1:0] != 2'b00));

  assign in_fault = !in_legal || in_oob
                 || (in_mis && !SPLIT_MISALIGNED);

  // Only halfwords and words are split.
  assign last_cnt = req_q.f3[1] ? 2'd3 : 2'd1;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          req_d   = in_req;
          fault_d = in_fault;
          cnt_d   = 2'd0;
          buf_d   = 32'd0;
          if (in_fault)
            state_d = ST_RESP;
          else if (in_mis)
            state_d = ST_SPLIT;
          else
            state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!req_q.we)
          buf_d = bus.mem_rdata_i;
        state_d = ST_RESP;
      end
      ST_SPLIT: begin
        if (!req_q.we)
          buf_d[{cnt_q, 3'b000} +: 8] =
            bus.mem_rdata_i[7:0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_cnt)
          state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= 2'd0;
      buf_q   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      fault_q <= fault_d;
    end
  end

  lsu_ctrl_load_extend u_ext (
    .funct3_i (req_q.f3),
    .buf_i    (buf_q),
    .data_o   (ext)
  );

  always_comb begin
    bus.req_ready_o  = (state_q == ST_IDLE);
    bus.stall_o      = (state_q != ST_IDLE);
    bus.resp_valid_o = 1'b0;
    bus.resp_data_o  = 32'd0;
    bus.resp_rd_o    = 5'd0;
    bus.resp_fault_o = 1'b0;
    bus.mem_addr_o   = 32'd0;
    bus.mem_data_o   = 32'd0;
    bus.mem_funct3_o = 3'd0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    unique case (state_q)
      ST_ACCESS: begin
        bus.mem_addr_o   = req_q.addr;
        bus.mem_funct3_o = req_q.f3;
        bus.mem_data_o   = req_q.wdata;
        bus.mem_read_o   = !req_q.we;
        bus.mem_write_o  = req_q.we;
      end
      ST_SPLIT: begin
        bus.mem_addr_o  = req_q.addr + {30'b0, cnt_q};
        bus.mem_read_o  = !req_q.we;
        bus.mem_write_o = req_q.we;
        if (req_q.we) begin
          bus.mem_funct3_o = F3_SB;
          bus.mem_data_o   = {24'b0,
            req_q.wdata[{cnt_q, 3'b000} +: 8]};
        end else begin
          bus.mem_funct3_o = F3_LBU;
        end
      end
      ST_RESP: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_fault_o = fault_q;
        bus.resp_rd_o    = req_q.we ? 5'd0 : req_q.rd;
        bus.resp_data_o  = (req_q.we || fault_q) ?
                           32'd0 : ext;
      end
      default: ;
    endcase
  end

endmodule
